// File: rtl/div_pkg.sv
// ============================================================================
// Module      : div_pkg
// Description : Shared widths, step count and control-FSM state encoding for
//               the 8-by-4 sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int DIV_STEPS  = 8;
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/div8by4_datapath.sv
// ============================================================================
// Module      : div8by4_datapath
// Description : Shift/subtract datapath of the restoring divider. Holds the
//               dividend shifter, divisor, partial remainder, quotient and the
//               registered results. Driven by load/step/latch strobes.
//               Optional macro DIV8BY4_ZERO_CHECK_EN adds the divide-by-zero
//               result override and flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div8by4_datapath
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic                  step,
    input  logic                  latch,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder
`ifdef DIV8BY4_ZERO_CHECK_EN
    ,
    output logic                  divisor_zero,
    output logic                  div_by_zero
`endif
);

    logic [DIVIDEND_W-1:0] r_a;
    logic [DIVISOR_W-1:0]  r_d;
    logic [DIVISOR_W:0]    r_r;
    logic [DIVIDEND_W-1:0] r_q;

    logic [DIVISOR_W:0]    w_trial;
    logic                  w_fits;
    logic [DIVISOR_W:0]    w_diff;
    logic                  w_unused;

    // Trial subtract: bring the next dividend bit into the partial remainder.
    assign w_trial  = {r_r[DIVISOR_W-1:0], r_a[DIVIDEND_W-1]};
    assign w_fits   = (w_trial >= {1'b0, r_d});
    assign w_diff   = w_trial - {1'b0, r_d};
    // R[4] only matters transiently inside the trial; after a restore it is 0
    // for a nonzero divisor and it is never part of the reported remainder.
    assign w_unused = r_r[DIVISOR_W];

`ifdef DIV8BY4_ZERO_CHECK_EN
    assign divisor_zero = (r_d == '0);
`endif

    // Working registers: load operands on accept, one restoring step per strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a <= '0;
            r_d <= '0;
            r_r <= '0;
            r_q <= '0;
        end else if (enable) begin
            if (load) begin
                r_a <= dividend;
                r_d <= divisor;
                r_r <= '0;
                r_q <= '0;
            end else if (step) begin
                r_r <= w_fits ? w_diff : w_trial;
                r_q <= {r_q[DIVIDEND_W-2:0], w_fits};
                r_a <= {r_a[DIVIDEND_W-2:0], 1'b0};
            end
        end
    end

    // Result registers: updated only at DONE, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            quotient    <= '0;
            remainder   <= '0;
`ifdef DIV8BY4_ZERO_CHECK_EN
            div_by_zero <= 1'b0;
`endif
        end else if (enable && latch) begin
`ifdef DIV8BY4_ZERO_CHECK_EN
            // Zero divisor skips all steps, so r_a still holds the dividend.
            if (r_d == '0) begin
                quotient    <= '1;
                remainder   <= r_a[DIVISOR_W-1:0];
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= r_q;
                remainder   <= r_r[DIVISOR_W-1:0];
                div_by_zero <= 1'b0;
            end
`else
            quotient  <= r_q;
            remainder <= r_r[DIVISOR_W-1:0];
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/div8by4.sv
// ============================================================================
// Module      : div8by4
// Description : Sequential restoring divider, 8-bit dividend / 4-bit divisor,
//               one quotient bit per enabled cycle. Control FSM here, datapath
//               in div8by4_datapath. Optional macro DIV8BY4_ZERO_CHECK_EN
//               short-circuits a zero divisor and exposes div_by_zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div8by4
    import div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  busy,
    output logic                  done
`ifdef DIV8BY4_ZERO_CHECK_EN
    ,
    output logic                  div_by_zero
`endif
);

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(DIV_STEPS - 1);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             w_load;
    logic             w_step;
    logic             w_latch;
`ifdef DIV8BY4_ZERO_CHECK_EN
    logic             w_divisor_zero;
`endif

    assign busy = (r_state != IDLE);
    assign done = r_done;

    // State register; enable=0 freezes the controller.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (enable) begin
            r_state <= w_next;
        end
    end

    // Next state and datapath strobes; nothing fires while disabled.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_step  = 1'b0;
        w_latch = 1'b0;
        if (enable) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_load = 1'b1;
                        w_next = RUN;
                    end
                end
                RUN: begin
`ifdef DIV8BY4_ZERO_CHECK_EN
                    if (w_divisor_zero) begin
                        w_next = DONE;
                    end else begin
                        w_step = 1'b1;
                        if (r_cnt == c_last_step) begin
                            w_next = DONE;
                        end
                    end
`else
                    w_step = 1'b1;
                    if (r_cnt == c_last_step) begin
                        w_next = DONE;
                    end
`endif
                end
                DONE: begin
                    w_latch = 1'b1;
                    w_next  = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Step counter: cleared at accept, advanced once per restoring step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (enable) begin
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Done pulse: set alongside the result latch, held while disabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_done <= 1'b0;
        end else if (enable) begin
            r_done <= w_latch;
        end
    end

    div8by4_datapath u_datapath (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .load         (w_load),
        .step         (w_step),
        .latch        (w_latch),
        .dividend     (dividend),
        .divisor      (divisor),
        .quotient     (quotient),
        .remainder    (remainder)
`ifdef DIV8BY4_ZERO_CHECK_EN
        ,
        .divisor_zero (w_divisor_zero),
        .div_by_zero  (div_by_zero)
`endif
    );

endmodule

`default_nettype wire
